// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the controller state encoding and the performance counter width.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } hc_state_t;

    localparam int CNT_W = 32;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_perf_cnt.sv
// Performance counters for hazard_ctrl: stall cycles, IF/ID flushes and
// load-use events. Each counter wraps naturally at 2^CNT_W.
// Instantiated by hazard_ctrl only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             load_use,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
);

    logic [2:0]       inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign inc = {load_use, flush, stall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // One wrapping event counter per increment source.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt_reg[gi] <= '0;
                else if (inc[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign stall_cycles   = cnt_reg[0];
    assign flush_count    = cnt_reg[1];
    assign load_use_count = cnt_reg[2];

endmodule : hazard_perf_cnt

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RV32 core.
// Sequences PC and stage-register enables/flushes around load-use hazards,
// EX-resolved redirects, instruction-fetch wait and data-memory wait, and
// holds a redirect target across an outstanding fetch (REDIR_WAIT).
// Optional feature macro: HAZARD_PERF_EN adds stall/flush/load-use counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_use_rs1,
    input  logic            ID_use_rs2,
    input  logic [4:0]      EX_rd,
    input  logic            EX_MemRead,
    input  logic            EX_redirect,
    input  logic [XLEN-1:0] EX_target,
    input  logic            IM_stall,
    input  logic            DM_stall,
    output logic            PC_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            IFID_write,
    output logic            IDEX_write,
    output logic            EXMEM_write,
    output logic            MEMWB_write,
    output logic            IFID_flush,
    output logic            IDEX_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
`endif
);

    hc_state_t       state_reg, state_next;
    logic [XLEN-1:0] tgt_reg, tgt_next;
    logic            load_use;

    // Load in EX writes a register the ID instruction reads; x0 never hazards.
    assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (EX_rd == ID_rs1)) ||
                       (ID_use_rs2 && (EX_rd == ID_rs2)));

    // The held target only matters while waiting out the fetch.
    assign redirect_pc = (state_reg == REDIR_WAIT) ? tgt_reg : EX_target;

    // State and held redirect target; both freeze while data memory stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
        end
    end

    // Prioritised control decode: DM freeze > redirect handling > load-use > IM wait.
    always_comb begin
        state_next     = state_reg;
        tgt_next       = tgt_reg;
        PC_write       = 1'b1;
        redirect_valid = 1'b0;
        IFID_write     = 1'b1;
        IDEX_write     = 1'b1;
        EXMEM_write    = 1'b1;
        MEMWB_write    = 1'b1;
        IFID_flush     = 1'b0;
        IDEX_flush     = 1'b0;
        if (DM_stall) begin
            // Whole pipe frozen; any redirect in EX is retried next cycle.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_write = 1'b0;
            MEMWB_write = 1'b0;
        end else if (state_reg == REDIR_WAIT) begin
            // Whatever arrives from fetch is wrong-path until the PC is redirected.
            IFID_flush = 1'b1;
            if (IM_stall) begin
                PC_write = 1'b0;
            end else begin
                redirect_valid = 1'b1;
                state_next     = RUN;
            end
        end else if (EX_redirect) begin
            // Redirect squashes IF and ID, including any load-use victim in ID.
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            if (IM_stall) begin
                PC_write   = 1'b0;
                tgt_next   = EX_target;
                state_next = REDIR_WAIT;
            end else begin
                redirect_valid = 1'b1;
            end
        end else if (load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else if (IM_stall) begin
            PC_write   = 1'b0;
            IFID_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic load_use_evt;

    // Count a load-use only when it is the condition actually driving the bubble.
    assign load_use_evt = load_use && !DM_stall && !EX_redirect &&
                          (state_reg == RUN);

    hazard_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall          (!PC_write),
        .flush          (IFID_flush),
        .load_use       (load_use_evt),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .load_use_count (load_use_count)
    );
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Control outputs are packed as
// {PC_write, redirect_valid, IFID_write, IDEX_write, EXMEM_write, MEMWB_write, IFID_flush, IDEX_flush}.
module tb_hazard_ctrl;

    localparam int XLEN = 32;

    localparam logic [7:0] C_IDLE   = 8'b1011_1100;
    localparam logic [7:0] C_LU     = 8'b0001_1101;
    localparam logic [7:0] C_RDR    = 8'b1111_1111;
    localparam logic [7:0] C_RDR_IM = 8'b0011_1111;
    localparam logic [7:0] C_WAIT   = 8'b0011_1110;
    localparam logic [7:0] C_WGO    = 8'b1111_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_IMST   = 8'b0011_1110;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      ID_rs1, ID_rs2, EX_rd;
    logic            ID_use_rs1, ID_use_rs2, EX_MemRead, EX_redirect;
    logic [XLEN-1:0] EX_target;
    logic            IM_stall, DM_stall;
    logic            PC_write, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            IFID_write, IDEX_write, EXMEM_write, MEMWB_write;
    logic            IFID_flush, IDEX_flush;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cycles, flush_count, load_use_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_use_rs1     (ID_use_rs1),
        .ID_use_rs2     (ID_use_rs2),
        .EX_rd          (EX_rd),
        .EX_MemRead     (EX_MemRead),
        .EX_redirect    (EX_redirect),
        .EX_target      (EX_target),
        .IM_stall       (IM_stall),
        .DM_stall       (DM_stall),
        .PC_write       (PC_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IFID_write     (IFID_write),
        .IDEX_write     (IDEX_write),
        .EXMEM_write    (EXMEM_write),
        .MEMWB_write    (MEMWB_write),
        .IFID_flush     (IFID_flush),
        .IDEX_flush     (IDEX_flush)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .load_use_count (load_use_count)
`endif
    );

    function automatic logic [7:0] ctrl();
        return {PC_write, redirect_valid, IFID_write, IDEX_write,
                EXMEM_write, MEMWB_write, IFID_flush, IDEX_flush};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Drive one cycle's inputs, then let combinational outputs settle.
    task automatic drive(input logic rdr, input logic [31:0] tgt, input logic ims,
                         input logic dms, input logic mrd, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2);
        EX_redirect = rdr;
        EX_target   = tgt;
        IM_stall    = ims;
        DM_stall    = dms;
        EX_MemRead  = mrd;
        EX_rd       = rd;
        ID_rs1      = r1;
        ID_use_rs1  = u1;
        ID_rs2      = r2;
        ID_use_rs2  = u2;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ctrl", {24'd0, ctrl()}, {24'd0, C_IDLE});
        check("reset_rpc", redirect_pc, 32'h55);
`ifdef HAZARD_PERF_EN
        check("reset_stall_cnt", stall_cycles, 32'd0);
`endif
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Load-use on rs1: exactly one bubble
        drive(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd1, 0);
        check("lu_rs1", {24'd0, ctrl()}, {24'd0, C_LU});
        tick();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd1, 0);
        check("lu_after", {24'd0, ctrl()}, {24'd0, C_IDLE});
        tick();
        // Load-use on rs2
        drive(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1);
        check("lu_rs2", {24'd0, ctrl()}, {24'd0, C_LU});
        tick();
        // x0 destination never stalls
        drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        check("lu_x0", {24'd0, ctrl()}, {24'd0, C_IDLE});
        tick();
        // Matching register but not actually read
        drive(0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd9, 0);
        check("lu_unused", {24'd0, ctrl()}, {24'd0, C_IDLE});
        tick();
        // Redirect with fetch ready
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rdr_ctrl", {24'd0, ctrl()}, {24'd0, C_RDR});
        check("rdr_pc", redirect_pc, 32'h100);
        tick();
`ifdef HAZARD_PERF_EN
        check("perf_load_use", load_use_count, 32'd2);
        check("perf_flush", flush_count, 32'd1);
        check("perf_stall", stall_cycles, 32'd2);
`endif

        // Redirect during IM wait, 3 more wait cycles
        drive(1, 32'h200, 1, 0, 0, 0, 0, 0, 0, 0);
        check("rdrim_ctrl", {24'd0, ctrl()}, {24'd0, C_RDR_IM});
        tick();
        for (int i = 0; i < 3; i++) begin
            // Load-use pattern in ID must not matter: it is wrong-path
            drive(0, 32'h999, 1, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0);
            check($sformatf("wait_%0d", i), {24'd0, ctrl()}, {24'd0, C_WAIT});
            tick();
        end
        drive(0, 32'h999, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wgo_ctrl", {24'd0, ctrl()}, {24'd0, C_WGO});
        check("wgo_pc", redirect_pc, 32'h200);
        tick();
        drive(0, 32'h999, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wgo_back_run", {24'd0, ctrl()}, {24'd0, C_IDLE});
        tick();

        // DM freeze over a pending redirect
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h300, 0, 1, 0, 0, 0, 0, 0, 0);
            check($sformatf("dm_freeze_%0d", i), {24'd0, ctrl()}, {24'd0, C_FREEZE});
            tick();
        end
        drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        check("dm_release", {24'd0, ctrl()}, {24'd0, C_RDR});
        check("dm_release_pc", redirect_pc, 32'h300);
        tick();

        // Redirect beats load-use
        drive(1, 32'h340, 0, 0, 1, 5'd6, 5'd6, 1, 5'd0, 0);
        check("rdr_over_lu", {24'd0, ctrl()}, {24'd0, C_RDR});
        tick();
        // IM stall alone, and load-use together with IM stall
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("im_only", {24'd0, ctrl()}, {24'd0, C_IMST});
        tick();
        drive(0, 0, 1, 0, 1, 5'd8, 5'd0, 0, 5'd8, 1);
        check("lu_with_im", {24'd0, ctrl()}, {24'd0, C_LU});
        tick();

        // DM freeze holds REDIR_WAIT and its target
        drive(1, 32'h500, 1, 0, 0, 0, 0, 0, 0, 0);
        check("rdrim2_ctrl", {24'd0, ctrl()}, {24'd0, C_RDR_IM});
        tick();
        drive(0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("wait_dm_freeze", {24'd0, ctrl()}, {24'd0, C_FREEZE});
        tick();
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wait_dm_go", {24'd0, ctrl()}, {24'd0, C_WGO});
        check("wait_dm_go_pc", redirect_pc, 32'h500);
        tick();

        // Reset in the middle of REDIR_WAIT discards the pending redirect
        drive(1, 32'h400, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0);
        check("wait3_ctrl", {24'd0, ctrl()}, {24'd0, C_WAIT});
        rst = 1'b0;
        drive(0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_ctrl", {24'd0, ctrl()}, {24'd0, C_IDLE});
        check("rst_mid_pc", redirect_pc, 32'h77);
        check("rst_mid_tgt", dut.tgt_reg, 32'h0);
`ifdef HAZARD_PERF_EN
        check("rst_mid_lu_cnt", load_use_count, 32'd0);
`endif
        tick();
        rst = 1'b1;
        drive(0, 32'h78, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_run", {24'd0, ctrl()}, {24'd0, C_IDLE});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. It sequences the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC around four events: load-use hazards, EX-resolved redirects (taken branch or jump), instruction-memory wait and data-memory wait. It complements the combinational EX-stage forwarding mux by removing the one hazard forwarding cannot cover, and it holds a pending redirect across an outstanding instruction fetch.

## Interface
Parameters:
- XLEN, 32, PC/target width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1  ID instruction actually reads rs1/rs2
- EX_rd  in  5  destination of the instruction in EX
- EX_MemRead  in  1  EX instruction is a load
- EX_redirect  in  1  taken branch or jump resolved in EX
- EX_target  in  XLEN  redirect target from EX
- IM_stall  in  1  instruction fetch not complete
- DM_stall  in  1  data access in MEM not complete
- PC_write  out  1  PC register load enable
- redirect_valid  out  1  PC loads redirect_pc instead of sequential PC
- redirect_pc  out  XLEN  redirect target
- IFID_write, IDEX_write, EXMEM_write, MEMWB_write  out  1  stage register load enables
- IFID_flush, IDEX_flush  out  1  load NOP instead of the incoming value (asserted only together with the matching write)

## Operation
- States: RUN, REDIR_WAIT. 1 state bit plus XLEN-bit target register tgt_q.
- Priority of conditions, highest first:
  - DM_stall=1: all *_write=0, PC_write=0, flushes=0, redirect_valid=0; state and tgt_q hold. An EX_redirect present is deferred (EX is frozen).
  - RUN, EX_redirect=1, IM_stall=0: redirect_valid=1, redirect_pc=EX_target, PC_write=1, IFID_flush=1, IDEX_flush=1, all writes=1.
  - RUN, EX_redirect=1, IM_stall=1: tgt_q<=EX_target, next state REDIR_WAIT; PC_write=0; IFID_flush=1, IDEX_flush=1, all writes=1.
  - REDIR_WAIT, IM_stall=1: PC_write=0, IFID_flush=1, other writes=1.
  - REDIR_WAIT, IM_stall=0: redirect_valid=1, redirect_pc=tgt_q, PC_write=1, IFID_flush=1 (drop wrong-path fetch), other writes=1; next state RUN.
  - Load-use (EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & EX_rd==ID_rs1) | (ID_use_rs2 & EX_rd==ID_rs2))): PC_write=0, IFID_write=0, IDEX_flush=1, EX/MEM and MEM/WB advance. Applies with or without IM_stall.
  - IM_stall only: PC_write=0, IFID_flush=1 (bubble), rest advance.
  - Otherwise: all writes=1, no flush.
- Redirect overrides load-use: the ID instruction is wrong-path.
- EX_redirect is ignored in REDIR_WAIT. It cannot occur, because only bubbles reach EX.

## Timing
- All control outputs are combinational from state, tgt_q and inputs, with zero-cycle latency.
- Load-use costs exactly one bubble. Redirect costs 2 cycles plus the remaining IM wait.
- State and tgt_q update on the rising edge of clk, only when DM_stall=0.
- Reset asserted (rst=0) at any time: state=RUN, tgt_q=0, counters=0, and a pending redirect is discarded.
- Outputs with reset asserted and inputs idle: PC_write=1, all *_write=1, flushes=0, redirect_valid=0, redirect_pc=EX_target.
- IM_stall falling while DM_stall=1: no action. The fetch unit holds its instruction until PC_write=1.

## Configuration
- HAZARD_PERF_EN defined: adds output ports stall_cycles, flush_count, load_use_count (32 bits each). They count cycles with PC_write=0, cycles with IFID_flush=1, and load-use events respectively. Each counter wraps at 2^32 and resets to 0.
- HAZARD_PERF_EN undefined: these ports and registers do not exist. Control behaviour is identical.

## Structure
- The shared package holds the state enum (RUN, REDIR_WAIT) and the counter width constant.
- The counters live in one sub-module, hazard_perf_cnt, instantiated only under HAZARD_PERF_EN.

## Test plan
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle with PC_write=0, IFID_write=0, IDEX_flush=1. Same case with EX_rd=0 -> no stall.
- Redirect, IM ready: EX_redirect=1, EX_target=0x100 -> same cycle redirect_valid=1, redirect_pc=0x100, IFID_flush=IDEX_flush=1.
- Redirect during IM wait: EX_redirect=1, EX_target=0x200, IM_stall=1 for 3 more cycles -> REDIR_WAIT with PC_write=0 and IFID_flush=1. On the cycle IM_stall falls: redirect_valid=1, redirect_pc=0x200, then RUN.
- DM freeze: DM_stall=1 for 4 cycles while EX_redirect=1 -> all writes 0 and no redirect. Redirect fires in the cycle DM_stall falls.
- Reset mid-REDIR_WAIT: rst=0 -> RUN, tgt_q=0, redirect_valid=0 with IM_stall=0.
- HAZARD_PERF_EN: 2 load-use events plus 1 redirect -> load_use_count=2, flush_count=1, stall_cycles=2.
